// File: rtl/ddram_rsp_pkg.sv
// Shared types and constants for the DDRAM memory-side responder.
// Build option: DDRAM_RSP_STALL_EN enables pseudo-random BUSY stalls.
package ddram_rsp_pkg;

    localparam int          BURST_W    = 8;
    localparam int          RD_LAT_MAX = 8;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        RBURST,
        WBURST
    } state_t;

    // A burst count of zero is treated as a single beat.
    function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] cnt);
        return (cnt == '0) ? BURST_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/ddram_rsp_mem.sv
// Simple dual-port 2^AW x 64 backing store with byte-lane write enables
// and a one-cycle registered read port.
// Build option: none (DDRAM_RSP_STALL_EN is handled in the top).
module ddram_rsp_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [7:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [63:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [2**AW];

    // Byte-masked write port.
    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port; the output register clears on reset so DOUT starts at zero.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/ddram_responder.sv
// DDRAM responder: stands in for the DDR bridge, serving single-beat and burst
// reads/writes from an on-chip array with in-order read beats and BUSY backpressure.
// Build option: define DDRAM_RSP_STALL_EN to add LFSR-driven random BUSY stalls
// in IDLE and WBURST.
module ddram_responder
    import ddram_rsp_pkg::*;
#(
    parameter int          AW         = 12,
    parameter int          RD_LAT     = 2,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic         DDRAM_CLK,
    input  logic         DDRAM_RESET_N,
    output logic         DDRAM_BUSY,
    input  logic [7:0]   DDRAM_BURSTCNT,
    input  logic [28:0]  DDRAM_ADDR,
    output logic [63:0]  DDRAM_DOUT,
    output logic         DDRAM_DOUT_READY,
    input  logic         DDRAM_RD,
    input  logic [63:0]  DDRAM_DIN,
    input  logic [7:0]   DDRAM_BE,
    input  logic         DDRAM_WE,
    output logic         PROTO_ERR
);

    // Elaboration-time parameter sanity checks.
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("ddram_responder: RD_LAT must be 1..%0d", RD_LAT_MAX);
    end
    if (AW < 1 || AW > 28) begin : g_bad_aw
        $error("ddram_responder: AW must be 1..28");
    end
    if (STALL_SEED == 16'h0) begin : g_bad_seed
        $error("ddram_responder: STALL_SEED must be non-zero");
    end

    state_t               r_state;
    state_t               w_next;
    logic                 r_init;
    logic                 r_proto;
    logic [AW-1:0]        r_addr;
    logic [BURST_W-1:0]   r_rem;
    logic [BURST_W-1:0]   r_out_rem;
    logic                 r_q_vld;

    logic [AW-1:0]        w_idx;
    logic [BURST_W-1:0]   w_n;
    logic                 w_busy;
    logic                 w_stall;
    logic                 w_last_out;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [AW-1:0]        w_mem_addr;
    logic                 w_proto_set;
    logic [63:0]          w_rd_data;
    logic                 w_unused_addr;

    assign w_idx         = DDRAM_ADDR[AW-1:0];
    assign w_unused_addr = ^DDRAM_ADDR[28:AW];
    assign w_n           = eff_burst(DDRAM_BURSTCNT);
    assign w_last_out    = DDRAM_DOUT_READY && (r_out_rem == BURST_W'(1));
    assign DDRAM_BUSY    = w_busy;
    assign PROTO_ERR     = r_proto;

`ifdef DDRAM_RSP_STALL_EN
    logic [15:0] r_lfsr;

    // Free-running LFSR; its low two bits pick roughly one stall cycle in four.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_lfsr <= STALL_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // State register, post-reset BUSY hold and sticky protocol flag.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_state <= IDLE;
            r_init  <= 1'b1;
            r_proto <= 1'b0;
        end else begin
            r_state <= w_next;
            r_init  <= 1'b0;
            if (w_proto_set) begin
                r_proto <= 1'b1;
            end
        end
    end

    // Next-state, BUSY and array-port control.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b1;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_addr  = r_addr;
        w_proto_set = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy     = r_init | w_stall;
                w_mem_addr = w_idx;
                if (!w_busy) begin
                    if (DDRAM_WE) begin
                        // A write always wins; a simultaneous read is dropped and flagged.
                        w_mem_we    = 1'b1;
                        w_proto_set = DDRAM_RD;
                        if (w_n > BURST_W'(1)) begin
                            w_next = WBURST;
                        end
                    end else if (DDRAM_RD) begin
                        w_mem_re = 1'b1;
                        w_next   = RBURST;
                    end
                end
            end
            RBURST: begin
                // Busy until the cycle that presents the last beat.
                w_busy   = !w_last_out;
                w_mem_re = (r_rem != '0);
                if (w_last_out) begin
                    w_next = IDLE;
                end
            end
            WBURST: begin
                w_busy = w_stall;
                if (!w_busy) begin
                    w_proto_set = DDRAM_RD;
                    if (DDRAM_WE) begin
                        w_mem_we = 1'b1;
                        if (r_rem == BURST_W'(1)) begin
                            w_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Burst address and beat counters.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_addr    <= '0;
            r_rem     <= '0;
            r_out_rem <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (!w_busy && (DDRAM_WE || DDRAM_RD)) begin
                    r_addr    <= w_idx + 1'b1;
                    r_rem     <= w_n - 1'b1;
                    r_out_rem <= w_n;
                end
            end else if (w_mem_we || w_mem_re) begin
                r_addr <= r_addr + 1'b1;
                r_rem  <= r_rem - 1'b1;
            end
            if (r_state == RBURST && DDRAM_DOUT_READY) begin
                r_out_rem <= r_out_rem - 1'b1;
            end
        end
    end

    // Marks the cycle in which the array read register holds a requested beat.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_q_vld <= 1'b0;
        end else begin
            r_q_vld <= w_mem_re;
        end
    end

    ddram_rsp_mem #(
        .AW(AW)
    ) u_mem (
        .clk     (DDRAM_CLK),
        .rst_n   (DDRAM_RESET_N),
        .i_we    (w_mem_we),
        .i_be    (DDRAM_BE),
        .i_waddr (w_mem_addr),
        .i_wdata (DDRAM_DIN),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_addr),
        .o_rdata (w_rd_data)
    );

    // The array read costs one cycle; the remaining RD_LAT-1 cycles come from this delay line.
    if (RD_LAT == 1) begin : g_no_dly
        assign DDRAM_DOUT       = w_rd_data;
        assign DDRAM_DOUT_READY = r_q_vld;
    end else begin : g_dly
        logic [63:0]       r_dly_data [RD_LAT-1];
        logic [RD_LAT-2:0] r_dly_vld;

        // Shift read data and valid together so beats stay aligned with DOUT_READY.
        always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
            if (!DDRAM_RESET_N) begin
                r_dly_vld <= '0;
                for (int i = 0; i < RD_LAT-1; i++) begin
                    r_dly_data[i] <= '0;
                end
            end else begin
                r_dly_data[0] <= w_rd_data;
                r_dly_vld[0]  <= r_q_vld;
                for (int i = 1; i < RD_LAT-1; i++) begin
                    r_dly_data[i] <= r_dly_data[i-1];
                    r_dly_vld[i]  <= r_dly_vld[i-1];
                end
            end
        end

        assign DDRAM_DOUT       = r_dly_data[RD_LAT-2];
        assign DDRAM_DOUT_READY = r_dly_vld[RD_LAT-2];
    end

endmodule

// File: tb/tb_ddram_responder.sv
// Directed testbench for ddram_responder (default build, stalls disabled).
module tb_ddram_responder;

    localparam int AW     = 12;
    localparam int RD_LAT = 2;

    logic         clk;
    logic         rst_n;
    logic         busy;
    logic [7:0]   burstcnt;
    logic [28:0]  addr;
    logic [63:0]  dout;
    logic         dout_ready;
    logic         rd;
    logic [63:0]  din;
    logic [7:0]   be;
    logic         we;
    logic         proto_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] wr_data [8];
    logic [63:0] rd_q    [$];
    int          rd_cyc  [$];
    logic        rd_busy [$];
    logic        rd_busy1;
    logic        rd_after;

    ddram_responder #(
        .AW        (AW),
        .RD_LAT    (RD_LAT),
        .STALL_SEED(16'hACE1)
    ) dut (
        .DDRAM_CLK        (clk),
        .DDRAM_RESET_N    (rst_n),
        .DDRAM_BUSY       (busy),
        .DDRAM_BURSTCNT   (burstcnt),
        .DDRAM_ADDR       (addr),
        .DDRAM_DOUT       (dout),
        .DDRAM_DOUT_READY (dout_ready),
        .DDRAM_RD         (rd),
        .DDRAM_DIN        (din),
        .DDRAM_BE         (be),
        .DDRAM_WE         (we),
        .PROTO_ERR        (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Wait (bounded) at negedges for BUSY low; an expired bound counts as a failure.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_checks++;
            $display("FAIL %s: BUSY stuck high, got %0b want 0", tag, busy);
        end
    endtask

    // Drive nbeats write beats from wr_data; starts and ends at a negedge.
    task automatic do_write(input logic [28:0] a, input logic [7:0] bcnt,
                            input logic [7:0] bemask, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            wait_ready("write");
            we       = 1'b1;
            addr     = a;
            burstcnt = bcnt;
            be       = bemask;
            din      = wr_data[i];
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    // Issue one read command and collect up to nexp beats with their cycle offsets.
    task automatic do_read(input logic [28:0] a, input logic [7:0] bcnt, input int nexp);
        rd_q.delete();
        rd_cyc.delete();
        rd_busy.delete();
        wait_ready("read");
        rd       = 1'b1;
        addr     = a;
        burstcnt = bcnt;
        @(negedge clk);
        rd       = 1'b0;
        rd_busy1 = busy;
        for (int c = 1; c <= 40 && rd_q.size() < nexp; c++) begin
            if (c > 1) @(negedge clk);
            if (dout_ready) begin
                rd_q.push_back(dout);
                rd_cyc.push_back(c);
                rd_busy.push_back(busy);
            end
        end
        @(negedge clk);
        rd_after = dout_ready;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %0b want 1", busy); else n_pass++;
        n_checks++; if (dout_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", dout_ready); else n_pass++;
        n_checks++; if (dout !== 64'h0) $display("FAIL reset_dout: got %h want 0", dout); else n_pass++;
        n_checks++; if (proto_err !== 1'b0) $display("FAIL reset_proto: got %0b want 0", proto_err); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL release_busy: got %0b want 1", busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL first_edge_busy: got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_single;
        wr_data[0] = 64'h1122334455667788;
        do_write(29'h10, 8'd1, 8'hFF, 1);
        do_read(29'h10, 8'd1, 1);
        n_checks++; if (rd_q.size() !== 1) $display("FAIL single_count: got %0d want 1", rd_q.size()); else n_pass++;
        n_checks++; if (rd_q[0] !== 64'h1122334455667788) $display("FAIL single_data: got %h want 1122334455667788", rd_q[0]); else n_pass++;
        n_checks++; if (rd_cyc[0] !== RD_LAT) $display("FAIL single_latency: got %0d want %0d", rd_cyc[0], RD_LAT); else n_pass++;
        n_checks++; if (rd_busy1 !== 1'b1) $display("FAIL single_busy_after_accept: got %0b want 1", rd_busy1); else n_pass++;
        n_checks++; if (rd_busy[0] !== 1'b0) $display("FAIL single_busy_last: got %0b want 0", rd_busy[0]); else n_pass++;
        n_checks++; if (rd_after !== 1'b0) $display("FAIL single_extra_beat: got %0b want 0", rd_after); else n_pass++;
        // Zero burst count behaves as one beat.
        do_read(29'h10, 8'd0, 1);
        n_checks++; if (rd_q.size() !== 1 || rd_after !== 1'b0) $display("FAIL bcnt0_beats: got %0d beats, trailing=%0b want 1,0", rd_q.size(), rd_after); else n_pass++;
    endtask

    task automatic test_byte_enable;
        wr_data[0] = 64'h0123456789ABCDEF;
        do_write(29'h0, 8'd1, 8'hFF, 1);
        wr_data[0] = 64'hFFFFFFFFFFFFFFFF;
        do_write(29'h0, 8'd1, 8'h0C, 1);
        do_read(29'h0, 8'd1, 1);
        n_checks++; if (rd_q[0] !== 64'h01234567FFFFCDEF) $display("FAIL be_0c: got %h want 01234567ffffcdef", rd_q[0]); else n_pass++;
        wr_data[0] = 64'h0;
        do_write(29'h0, 8'd1, 8'h00, 1);
        do_read(29'h0, 8'd1, 1);
        n_checks++; if (rd_q[0] !== 64'h01234567FFFFCDEF) $display("FAIL be_00: got %h want 01234567ffffcdef", rd_q[0]); else n_pass++;
    endtask

    task automatic test_burst;
        logic [63:0] exp;
        for (int i = 0; i < 4; i++) wr_data[i] = 64'hD0D0_0000_0000_0000 + 64'(i * 17);
        do_write(29'h20, 8'd4, 8'hFF, 4);
        do_read(29'h20, 8'd4, 4);
        n_checks++; if (rd_q.size() !== 4) $display("FAIL burst_count: got %0d want 4", rd_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            exp = 64'hD0D0_0000_0000_0000 + 64'(i * 17);
            n_checks++; if (rd_q[i] !== exp) $display("FAIL burst_data[%0d]: got %h want %h", i, rd_q[i], exp); else n_pass++;
            n_checks++; if (rd_cyc[i] !== RD_LAT + i) $display("FAIL burst_cycle[%0d]: got %0d want %0d", i, rd_cyc[i], RD_LAT + i); else n_pass++;
            n_checks++; if (rd_busy[i] !== (i != 3)) $display("FAIL burst_busy[%0d]: got %0b want %0b", i, rd_busy[i], (i != 3)); else n_pass++;
        end
        n_checks++; if (rd_after !== 1'b0) $display("FAIL burst_extra_beat: got %0b want 0", rd_after); else n_pass++;
    endtask

    task automatic test_wrap;
        wr_data[0] = 64'hE0E0E0E0_00000FFF;
        wr_data[1] = 64'hE1E1E1E1_00000000;
        do_write(29'hFFF, 8'd2, 8'hFF, 2);
        do_read(29'h0AB0_0FFF, 8'd2, 2);
        n_checks++; if (rd_q.size() !== 2) $display("FAIL wrap_count: got %0d want 2", rd_q.size()); else n_pass++;
        n_checks++; if (rd_q[0] !== 64'hE0E0E0E0_00000FFF) $display("FAIL wrap_beat0: got %h want e0e0e0e000000fff", rd_q[0]); else n_pass++;
        n_checks++; if (rd_q[1] !== 64'hE1E1E1E1_00000000) $display("FAIL wrap_beat1: got %h want e1e1e1e100000000", rd_q[1]); else n_pass++;
        do_read(29'h0, 8'd1, 1);
        n_checks++; if (rd_q[0] !== 64'hE1E1E1E1_00000000) $display("FAIL wrap_index0: got %h want e1e1e1e100000000", rd_q[0]); else n_pass++;
    endtask

    task automatic test_rd_we_conflict;
        logic saw = 1'b0;
        wait_ready("conflict");
        rd       = 1'b1;
        we       = 1'b1;
        addr     = 29'h30;
        burstcnt = 8'd1;
        be       = 8'hFF;
        din      = 64'hC0FFEE00_12345678;
        @(negedge clk);
        rd = 1'b0;
        we = 1'b0;
        for (int c = 0; c < 8; c++) begin
            saw |= dout_ready;
            @(negedge clk);
        end
        n_checks++; if (saw !== 1'b0) $display("FAIL conflict_ready: got %0b want 0", saw); else n_pass++;
        n_checks++; if (proto_err !== 1'b1) $display("FAIL conflict_proto: got %0b want 1", proto_err); else n_pass++;
        do_read(29'h30, 8'd1, 1);
        n_checks++; if (rd_q[0] !== 64'hC0FFEE00_12345678) $display("FAIL conflict_write: got %h want c0ffee0012345678", rd_q[0]); else n_pass++;
        n_checks++; if (proto_err !== 1'b1) $display("FAIL conflict_sticky: got %0b want 1", proto_err); else n_pass++;
    endtask

    task automatic test_reset_mid_burst;
        logic saw = 1'b0;
        logic busy_after;
        wait_ready("mid_reset");
        rd       = 1'b1;
        addr     = 29'h40;
        burstcnt = 8'd8;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || dout_ready !== 1'b0) $display("FAIL mid_reset_outputs: busy=%0b ready=%0b want 1,0", busy, dout_ready); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_release_busy: got %0b want 1", busy); else n_pass++;
        @(negedge clk);
        busy_after = busy;
        for (int c = 0; c < 12; c++) begin
            saw |= dout_ready;
            @(negedge clk);
        end
        n_checks++; if (busy_after !== 1'b0) $display("FAIL mid_busy_fall: got %0b want 0", busy_after); else n_pass++;
        n_checks++; if (saw !== 1'b0) $display("FAIL mid_stale_beat: got %0b want 0", saw); else n_pass++;
        n_checks++; if (proto_err !== 1'b0) $display("FAIL mid_proto_cleared: got %0b want 0", proto_err); else n_pass++;
        do_read(29'h10, 8'd1, 1);
        n_checks++; if (rd_q[0] !== 64'h1122334455667788) $display("FAIL mid_data_kept: got %h want 1122334455667788", rd_q[0]); else n_pass++;
        do_read(29'h20, 8'd4, 4);
        n_checks++; if (rd_q.size() !== 4 || rd_q[3] !== 64'hD0D0_0000_0000_0033) $display("FAIL mid_burst_kept: got %0d beats, last %h want 4, d0d0000000000033", rd_q.size(), rd_q[3]); else n_pass++;
    endtask

    initial begin
        rd       = 1'b0;
        we       = 1'b0;
        addr     = '0;
        burstcnt = 8'd1;
        din      = '0;
        be       = '0;
        rst_n    = 1'b0;
        for (int i = 0; i < 8; i++) wr_data[i] = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_byte_enable();
        test_burst();
        test_wrap();
        test_rd_we_conflict();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
